// File: rtl/cim_edram_req_router.sv
// rtl/cim_edram_req_router.sv - request router from one master stream to the CIM-core eDRAM banks
// Optional counters: define CIM_EDRAM_ROUTER_PERF_EN to build perf_req_cnt_o / perf_err_cnt_o.
module cim_edram_req_router #(
    parameter int          ADDR_W      = 64,
    parameter int          DATA_W      = 64,
    parameter int          NB_BANKS    = 16,
    parameter int          BANK_ADDR_W = 23,
    parameter logic [63:0] BASE_ADDR   = 64'h5000_0000,
    parameter int          MAX_OUTST   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [ADDR_W-1:0]          req_addr_i,
    input  logic                       req_we_i,
    input  logic [DATA_W/8-1:0]        req_be_i,
    input  logic [DATA_W-1:0]          req_wdata_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [DATA_W-1:0]          rsp_rdata_o,
    output logic                       rsp_err_o,
    output logic [NB_BANKS-1:0]        edram_req_valid_o,
    input  logic [NB_BANKS-1:0]        edram_req_ready_i,
    output logic [BANK_ADDR_W-1:0]     edram_req_addr_o,
    output logic                       edram_req_we_o,
    output logic [DATA_W/8-1:0]        edram_req_be_o,
    output logic [DATA_W-1:0]          edram_req_wdata_o,
    input  logic [NB_BANKS-1:0]        edram_rsp_valid_i,
    output logic [NB_BANKS-1:0]        edram_rsp_ready_o,
    input  logic [NB_BANKS*DATA_W-1:0] edram_rsp_rdata_i,
    output logic [31:0]                perf_req_cnt_o,
    output logic [31:0]                perf_err_cnt_o
);

    localparam int IDX_W  = $clog2(NB_BANKS);
    localparam int HI_LSB = BANK_ADDR_W + IDX_W;
    localparam int PTR_W  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W  = $clog2(MAX_OUTST + 1);
    localparam logic [ADDR_W-1:0] BASE_TRUNC = BASE_ADDR[ADDR_W-1:0];

    logic             w_hit;
    logic [IDX_W-1:0] w_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_head_err;
    logic [IDX_W-1:0] w_head_idx;
    logic [DATA_W-1:0] w_bank_rdata [NB_BANKS];

    logic             r_fifo_err [MAX_OUTST];
    logic [IDX_W-1:0] r_fifo_idx [MAX_OUTST];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_hit = (req_addr_i[ADDR_W-1:HI_LSB] == BASE_TRUNC[ADDR_W-1:HI_LSB]);
    assign w_idx = req_addr_i[BANK_ADDR_W +: IDX_W];

    assign edram_req_addr_o  = req_addr_i[BANK_ADDR_W-1:0];
    assign edram_req_we_o    = req_we_i;
    assign edram_req_be_o    = req_be_i;
    assign edram_req_wdata_o = req_wdata_i;

    assign w_full  = (r_count == CNT_W'(MAX_OUTST));
    assign w_empty = (r_count == '0);

    // Full blocks the push even when the head pops this cycle.
    always_comb begin
        edram_req_valid_o = '0;
        if (req_valid_i && w_hit && !w_full) begin
            edram_req_valid_o[w_idx] = 1'b1;
        end
    end

    assign req_ready_o = !w_full && (w_hit ? edram_req_ready_i[w_idx] : 1'b1);
    assign w_push      = req_valid_i && req_ready_o;

    genvar g;
    generate
        for (g = 0; g < NB_BANKS; g++) begin : g_rdata
            assign w_bank_rdata[g] = edram_rsp_rdata_i[g*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_head_err = r_fifo_err[r_rd_ptr];
    assign w_head_idx = r_fifo_idx[r_rd_ptr];

    // Only the bank at the FIFO head may hand over a response; others stall.
    always_comb begin
        rsp_valid_o       = 1'b0;
        rsp_err_o         = 1'b0;
        rsp_rdata_o       = '0;
        edram_rsp_ready_o = '0;
        w_pop             = 1'b0;
        if (!w_empty) begin
            if (w_head_err) begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = 1'b1;
                w_pop       = rsp_ready_i;
            end else begin
                rsp_valid_o                   = edram_rsp_valid_i[w_head_idx];
                rsp_rdata_o                   = w_bank_rdata[w_head_idx];
                edram_rsp_ready_o[w_head_idx] = rsp_ready_i;
                w_pop                         = edram_rsp_valid_i[w_head_idx] && rsp_ready_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_err[r_wr_ptr] <= !w_hit;
            r_fifo_idx[r_wr_ptr] <= w_idx;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef CIM_EDRAM_ROUTER_PERF_EN
    logic [31:0] r_perf_req;
    logic [31:0] r_perf_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perf_req <= '0;
            r_perf_err <= '0;
        end else begin
            if (w_push && (r_perf_req != 32'hFFFF_FFFF)) begin
                r_perf_req <= r_perf_req + 32'd1;
            end
            if (w_push && !w_hit && (r_perf_err != 32'hFFFF_FFFF)) begin
                r_perf_err <= r_perf_err + 32'd1;
            end
        end
    end

    assign perf_req_cnt_o = r_perf_req;
    assign perf_err_cnt_o = r_perf_err;
`else
    assign perf_req_cnt_o = 32'd0;
    assign perf_err_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_cim_edram_req_router.sv
// tb/tb_cim_edram_req_router.sv - directed and randomized bench for cim_edram_req_router
module tb_cim_edram_req_router;

    localparam int          NB    = 16;
    localparam int          DW    = 64;
    localparam logic [63:0] BASE  = 64'h5000_0000;
    localparam logic [63:0] SLOT  = 64'h80_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [63:0]       req_addr_i;
    logic              req_we_i;
    logic [7:0]        req_be_i;
    logic [63:0]       req_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [63:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic [NB-1:0]     edram_req_valid_o;
    logic [NB-1:0]     edram_req_ready_i;
    logic [22:0]       edram_req_addr_o;
    logic              edram_req_we_o;
    logic [7:0]        edram_req_be_o;
    logic [63:0]       edram_req_wdata_o;
    logic [NB-1:0]     edram_rsp_valid_i;
    logic [NB-1:0]     edram_rsp_ready_o;
    logic [NB*DW-1:0]  edram_rsp_rdata_i;
    logic [31:0]       perf_req_cnt_o;
    logic [31:0]       perf_err_cnt_o;

    always #5 clk = ~clk;

    cim_edram_req_router dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_addr_i        (req_addr_i),
        .req_we_i          (req_we_i),
        .req_be_i          (req_be_i),
        .req_wdata_i       (req_wdata_i),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_ready_i       (rsp_ready_i),
        .rsp_rdata_o       (rsp_rdata_o),
        .rsp_err_o         (rsp_err_o),
        .edram_req_valid_o (edram_req_valid_o),
        .edram_req_ready_i (edram_req_ready_i),
        .edram_req_addr_o  (edram_req_addr_o),
        .edram_req_we_o    (edram_req_we_o),
        .edram_req_be_o    (edram_req_be_o),
        .edram_req_wdata_o (edram_req_wdata_o),
        .edram_rsp_valid_i (edram_rsp_valid_i),
        .edram_rsp_ready_o (edram_rsp_ready_o),
        .edram_rsp_rdata_i (edram_rsp_rdata_i),
        .perf_req_cnt_o    (perf_req_cnt_o),
        .perf_err_cnt_o    (perf_err_cnt_o)
    );

    typedef struct { bit err; int bank; } ord_t;
    typedef struct { int bank; logic [63:0] data; } brsp_t;

    ord_t        ord_q[$];
    brsp_t       bk_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          perf_req = 0;
    int          perf_err = 0;
    logic [15:0] bank_rsp_en;
    logic [63:0] force_data;
    bit          use_force;
    bit          last_acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void decode(input logic [63:0] a, output bit hit, output int bank,
                                   output logic [63:0] off);
        hit  = (a >= BASE) && (a < BASE + 64'd16 * SLOT);
        bank = hit ? int'((a - BASE) / SLOT) : 0;
        off  = a % SLOT;
    endfunction

    function automatic bit front_of(input int b, output logic [63:0] d);
        bit found = 1'b0;
        d = '0;
        for (int i = 0; i < bk_q.size(); i++) begin
            if (!found && bk_q[i].bank == b) begin
                d     = bk_q[i].data;
                found = 1'b1;
            end
        end
        return found;
    endfunction

    task automatic drive_banks();
        logic [63:0] d;
        for (int b = 0; b < NB; b++) begin
            if (bank_rsp_en[b] && front_of(b, d)) begin
                edram_rsp_valid_i[b]          = 1'b1;
                edram_rsp_rdata_i[b*DW +: DW] = d;
            end else begin
                edram_rsp_valid_i[b]          = 1'b0;
                edram_rsp_rdata_i[b*DW +: DW] = {$urandom, $urandom};
            end
        end
    endtask

    // Reference: ordered list of outstanding requests plus per-bank pending responses.
    task automatic check_cycle();
        bit          hit, full, acc, exp_rv, exp_err;
        int          bank, h;
        logic [63:0] off, exp_data, d;
        logic [15:0] exp_ev, exp_rr;
        bit          exp_rdy;

        decode(req_addr_i, hit, bank, off);
        full    = (ord_q.size() >= 4);
        exp_ev  = (req_valid_i && hit && !full) ? (16'h1 << bank) : 16'h0;
        exp_rdy = !full && (hit ? edram_req_ready_i[bank] : 1'b1);
        chk("edram_req_valid", edram_req_valid_o, exp_ev);
        chk("req_ready", req_ready_o, exp_rdy);
        chk("edram_req_addr", edram_req_addr_o, off);
        if (exp_ev != 0) begin
            chk("edram_req_we", edram_req_we_o, req_we_i);
            chk("edram_req_wdata", edram_req_wdata_o, req_wdata_i);
        end

        exp_rv = 1'b0; exp_err = 1'b0; exp_data = '0; exp_rr = '0; h = 0;
        if (ord_q.size() > 0) begin
            if (ord_q[0].err) begin
                exp_rv  = 1'b1;
                exp_err = 1'b1;
            end else begin
                h      = ord_q[0].bank;
                exp_rv = edram_rsp_valid_i[h];
                if (front_of(h, d)) exp_data = d;
                exp_rr = rsp_ready_i ? (16'h1 << h) : 16'h0;
            end
        end
        chk("rsp_valid", rsp_valid_o, exp_rv);
        chk("edram_rsp_ready", edram_rsp_ready_o, exp_rr);
        if (exp_rv) begin
            chk("rsp_err", rsp_err_o, exp_err);
            chk("rsp_rdata", rsp_rdata_o, exp_data);
        end

        if (exp_rv && rsp_ready_i) begin
            if (!ord_q[0].err) begin
                for (int i = 0; i < bk_q.size(); i++) begin
                    if (bk_q[i].bank == h) begin
                        bk_q.delete(i);
                        break;
                    end
                end
            end
            void'(ord_q.pop_front());
        end
        acc = req_valid_i && exp_rdy;
        if (acc) begin
            ord_q.push_back('{err: !hit, bank: bank});
            perf_req++;
            if (!hit) perf_err++;
            if (hit) begin
                bk_q.push_back('{bank: bank,
                                 data: req_we_i ? 64'h0 : (use_force ? force_data : {$urandom, $urandom})});
                use_force = 1'b0;
            end
        end
        last_acc = acc;
    endtask

    task automatic step();
        drive_banks();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req_valid_i       = 1'b0;
        rsp_ready_i       = 1'b1;
        edram_req_ready_i = '1;
        bank_rsp_en       = '0;
    endtask

    task automatic issue(input logic [63:0] a, input bit we);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_we_i    = we;
        req_be_i    = 8'hFF;
        req_wdata_i = {$urandom, $urandom};
    endtask

    function automatic logic [63:0] gen_addr();
        logic [63:0] a;
        case ($urandom_range(0, 5))
            0, 1, 2: a = BASE + 64'($urandom_range(0, 15)) * SLOT + 64'($urandom_range(0, 32'h7F_FFFF) & ~32'h7);
            3:       a = 64'h5800_0000 + 64'($urandom_range(0, 255) * 8);
            4:       a = 64'h4FFF_FFF8;
            default: a = 64'h1_5000_0000 + 64'($urandom_range(0, 32'h7FF_FFFF));
        endcase
        return a;
    endfunction

    initial begin
        logic [63:0] bad [2];
        bad[0] = 64'h5800_0000;
        bad[1] = 64'h4FFF_FFF8;
        rst = 1'b1;
        set_idle();
        req_addr_i = '0; req_we_i = 1'b0; req_be_i = '0; req_wdata_i = '0;
        use_force = 1'b0; force_data = '0; last_acc = 1'b0;
        edram_rsp_valid_i = '0; edram_rsp_rdata_i = '0;
        drive_banks();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_edram_rsp_ready", edram_rsp_ready_o, 0);
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_perf_req", perf_req_cnt_o, 0);
        chk("rst_perf_err", perf_err_cnt_o, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(64'h5080_0010, 1'b0);
        use_force = 1'b1; force_data = 64'hDEAD;
        drive_banks(); #1;
        chk("t1_edram_valid", edram_req_valid_o, 16'h0002);
        chk("t1_edram_addr", edram_req_addr_o, 23'h10);
        step();
        set_idle(); bank_rsp_en = 16'h0002;
        drive_banks(); #1;
        chk("t1_rdata", rsp_rdata_o, 64'hDEAD);
        chk("t1_err", rsp_err_o, 0);
        step();

        issue(64'h5780_0008, 1'b1);
        req_wdata_i = 64'h1234;
        drive_banks(); #1;
        chk("t2_edram_valid", edram_req_valid_o, 16'h8000);
        chk("t2_edram_we", edram_req_we_o, 1);
        step();
        set_idle(); bank_rsp_en = 16'h8000;
        drive_banks(); #1;
        chk("t2_rsp_valid", rsp_valid_o, 1);
        chk("t2_rsp_err", rsp_err_o, 0);
        step();

        for (int i = 0; i < 2; i++) begin
            issue(bad[i], 1'b0);
            drive_banks(); #1;
            chk("t3_no_edram", edram_req_valid_o, 0);
            step();
            set_idle();
            drive_banks(); #1;
            chk("t3_rsp_valid", rsp_valid_o, 1);
            chk("t3_rsp_err", rsp_err_o, 1);
            chk("t3_rsp_rdata", rsp_rdata_o, 0);
            step();
        end

        set_idle();
        issue(BASE + 2 * SLOT, 1'b0); step();
        issue(BASE + 5 * SLOT, 1'b0); step();
        set_idle(); bank_rsp_en = 16'h0020;
        repeat (2) begin
            drive_banks(); #1;
            chk("t4_hold_bank5", edram_rsp_ready_o[5], 0);
            chk("t4_rsp_valid", rsp_valid_o, 0);
            step();
        end
        bank_rsp_en = 16'h0024;
        step();
        drive_banks(); #1;
        chk("t4_fwd_bank5", edram_rsp_ready_o, 16'h0020);
        chk("t4_rsp_valid5", rsp_valid_o, 1);
        step();

        set_idle();
        for (int b = 0; b < 4; b++) begin
            issue(BASE + 64'(b) * SLOT, 1'b0);
            step();
        end
        issue(BASE + 4 * SLOT, 1'b0);
        drive_banks(); #1;
        chk("t5_full_ready", req_ready_o, 0);
        chk("t5_full_edram", edram_req_valid_o, 0);
        rsp_ready_i = 1'b0; bank_rsp_en = 16'h0001;
        repeat (2) step();
        rsp_ready_i = 1'b1;
        step();
        drive_banks(); #1;
        chk("t5_accept_after_pop", req_ready_o, 1);
        step();
        set_idle(); bank_rsp_en = '1;
        repeat (8) step();

        set_idle(); rsp_ready_i = 1'b0;
        issue(64'h0, 1'b0); step();
        issue(BASE + 3 * SLOT, 1'b0); step();
        issue(BASE + 6 * SLOT, 1'b0); step();
        req_valid_i = 1'b0;
        drive_banks(); #1;
        chk("t6_pre_rsp_valid", rsp_valid_o, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_rsp_valid", rsp_valid_o, 0);
        chk("t6_rst_req_ready", req_ready_o, 1);
        ord_q.delete(); bk_q.delete(); perf_req = 0; perf_err = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_idle();
        step();

        last_acc = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!(req_valid_i && !last_acc)) begin
                issue(gen_addr(), 1'($urandom));
                req_valid_i = ($urandom_range(0, 3) != 0);
            end
            edram_req_ready_i = 16'($urandom);
            rsp_ready_i       = ($urandom_range(0, 3) != 0);
            bank_rsp_en       = 16'($urandom);
            step();
        end

        set_idle(); bank_rsp_en = '1;
        for (int c = 0; c < 100 && ord_q.size() > 0; c++) step();
        chk("drain_empty", 64'(ord_q.size()), 0);
        step();
`ifdef CIM_EDRAM_ROUTER_PERF_EN
        chk("perf_req_cnt", perf_req_cnt_o, 64'(perf_req));
        chk("perf_err_cnt", perf_err_cnt_o, 64'(perf_err));
`else
        chk("perf_req_cnt_off", perf_req_cnt_o, 0);
        chk("perf_err_cnt_off", perf_err_cnt_o, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cim_edram_req_router.md
Name: cim_edram_req_router

Overview:
- Request router sitting directly upstream of the 16 CIM-core eDRAM banks.
- Decodes a single master request stream against the eDRAM address map: base 0x5000_0000, 16 slots of 8 MiB each, bank n at 0x5000_0000 + n*0x80_0000.
- Forwards each in-range request to the selected bank and returns responses to the master in issue order.
- Generates decode-error responses locally for out-of-range addresses.

Parameters:
- ADDR_W, 64, master address width.
- DATA_W, 64, data width.
- NB_BANKS, 16, number of eDRAM banks (power of two).
- BANK_ADDR_W, 23, byte-offset width inside one bank (8 MiB).
- BASE_ADDR, 64'h5000_0000, base of bank 0; aligned to NB_BANKS*2^BANK_ADDR_W.
- MAX_OUTST, 4, maximum outstanding requests (order FIFO depth).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  1  master request valid.
- req_ready_o  out  1  master request accepted.
- req_addr_i  in  ADDR_W  byte address.
- req_we_i  in  1  write enable.
- req_be_i  in  DATA_W/8  byte enables.
- req_wdata_i  in  DATA_W  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  master accepts response.
- rsp_rdata_o  out  DATA_W  read data (0 for writes/errors).
- rsp_err_o  out  1  decode error.
- edram_req_valid_o  out  NB_BANKS  per-bank request valid (one-hot or zero).
- edram_req_ready_i  in  NB_BANKS  per-bank request ready.
- edram_req_addr_o  out  BANK_ADDR_W  broadcast in-bank offset.
- edram_req_we_o  out  1  broadcast write enable.
- edram_req_be_o  out  DATA_W/8  broadcast byte enables.
- edram_req_wdata_o  out  DATA_W  broadcast write data.
- edram_rsp_valid_i  in  NB_BANKS  per-bank response valid.
- edram_rsp_ready_o  out  NB_BANKS  per-bank response ready.
- edram_rsp_rdata_i  in  NB_BANKS*DATA_W  per-bank read data; bank n at [n*DATA_W +: DATA_W].
- perf_req_cnt_o  out  32  accepted request count.
- perf_err_cnt_o  out  32  decode error count.

Behaviour:
- Decode (combinational):
  - hit = (req_addr_i[ADDR_W-1 : BANK_ADDR_W+log2(NB_BANKS)] == BASE_ADDR upper bits).
  - idx = req_addr_i[BANK_ADDR_W +: log2(NB_BANKS)].
  - edram_req_addr_o = req_addr_i[BANK_ADDR_W-1:0].
- Request path (combinational, zero latency):
  - edram_req_valid_o[idx] = req_valid_i & hit & ~full; all other bits 0.
  - req_ready_o = ~full & (hit ? edram_req_ready_i[idx] : 1).
  - Handshake: valid must not depend on ready. The master holds all request fields stable while valid & ~ready.
- Order FIFO:
  - On accept, pushes {err=~hit, idx}.
  - full = (count == MAX_OUTST). Full blocks a push even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
- Response path (combinational from FIFO head):
  - Empty: rsp_valid_o=0, all edram_rsp_ready_o=0.
  - Head err=1: rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0. Pops on rsp_ready_i. No bank is involved.
  - Head err=0, bank h:
    - rsp_valid_o = edram_rsp_valid_i[h]; rsp_rdata_o = bank h data; rsp_err_o=0.
    - edram_rsp_ready_o[h] = rsp_ready_i; all other ready bits 0.
    - Pops on edram_rsp_valid_i[h] & rsp_ready_i.
  - Responses from non-head banks stall (ready low) until that bank reaches the head.
  - Every accepted bank request, read or write, yields exactly one bank response; per-bank responses arrive in order.
- Latency:
  - Response can be valid no earlier than the cycle after acceptance, since the FIFO is registered.
  - Decode-error response appears exactly 1 cycle after acceptance when the FIFO was empty.
- Reset:
  - rsp_valid_o=0, req_ready_o=0 except via the combinational rule with count=0.
  - FIFO pointers and count = 0, perf counters = 0.
- Reset mid-operation: outstanding entries are discarded. Banks must be reset in the same domain, so no stale bank response arrives after reset.

Optional Feature:
- Macro: CIM_EDRAM_ROUTER_PERF_EN.
- Defined:
  - perf_req_cnt_o increments on every accepted request.
  - perf_err_cnt_o increments on every accepted decode-error request.
  - Both counters are 32-bit and saturate at 0xFFFF_FFFF.
- Undefined: no counter flops; both outputs tied to 0.

Test Plan:
- Read at 0x5080_0010 → edram_req_valid_o = 16'h0002, addr 23'h10. Bank 1 returns 0xDEAD → rsp_rdata_o=0xDEAD, rsp_err_o=0.
- Write at 0x5780_0008, be=8'hFF, wdata 0x1234 → bank 15 strobed; bank 15 response → rsp_valid_o=1, rsp_err_o=0.
- Read at 0x5800_0000 and at 0x4FFF_FFF8 → no edram valid. Each gets rsp_err_o=1, rsp_rdata_o=0 one cycle after accept.
- Requests to bank 2 then bank 5; bank 5 responds first → edram_rsp_ready_o[5]=0 until bank 2 response is forwarded, then bank 5 is forwarded.
- 4 accepted requests with banks silent → req_ready_o=0 on the 5th. One response popped → 5th accepted next cycle. rsp_ready_i=0 holds the head response stable.
- Reset asserted with 3 outstanding → rsp_valid_o=0 immediately and count=0. With PERF_EN, 10 requests including 3 decode errors → perf_req_cnt_o=10, perf_err_cnt_o=3.
